// File: rtl/psmax_pkg.sv
// Shared constants, state encoding and helpers
// for the pseudo-softmax datapath stages.
package psmax_pkg;

  localparam int DW        = 8;
  localparam int Q_SCALE   = 256;
  localparam int RECIP_NUM = 32768;

  typedef enum logic [1:0] {
    ACCUM,
    NORM,
    WAIT,
    EMIT
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/psmax_lzd.sv
// Leading-one detector: index of the most significant set bit.
// Returns 0 when the input is all zeros.
module psmax_lzd #(
  parameter int SW = 11,
  parameter int MW = 4
) (
  input  logic [SW-1:0] d,
  output logic [MW-1:0] m
);

  always_comb begin
    m = '0;
    for (int i = 0; i < SW; i++)
      if (d[i]) m = MW'(i);
  end

endmodule

// File: rtl/psmax_normalizer.sv
// Buffers a vector, normalizes its sum through an external
// reciprocal unit and emits each element as a Q0.8 probability.
module psmax_normalizer
  import psmax_pkg::*;
#(
  parameter int N         = 8,
  parameter int RECIP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic [DW-1:0] recip_in,
  input  logic [DW-1:0] recip_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int AW = clog2(N);
  localparam int CW = AW + 1;
  localparam int SW = DW + AW;
  localparam int MW = clog2(SW);
  localparam int WW = clog2(RECIP_LAT + 1) + 1;

  state_t        state, nstate;
  logic [DW-1:0] mem [N];
  logic [SW-1:0] sum;
  logic [CW-1:0] count;
  logic [AW-1:0] idx;
  logic [AW-1:0] sel;
  logic [MW-1:0] m;
  logic [DW-1:0] r;
  logic [DW-1:0] rr;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] norm_w;
  logic [15:0]   prod;
  logic [15:0]   shifted;
  logic [DW-1:0] p;
  logic          in_hs, out_hs;
  logic          closing, last_out, wait_done;

  psmax_lzd #(.SW(SW), .MW(MW)) u_lzd (
    .d (sum),
    .m (m)
  );

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != ACCUM) || (count != '0);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign closing   = in_hs && (in_last || count == CW'(N - 1));
  assign last_out  = out_hs && (CW'(idx) + CW'(1) == count);
  assign wait_done = (state == WAIT) && (wcnt == WW'(RECIP_LAT));

  always_comb begin
    norm_w = '0;
    if (sum == '0)
      norm_w = SW'(128);
    else if (m < MW'(7))
      norm_w = sum << (MW'(7) - m);
    else
      norm_w = sum >> (m - MW'(7));
  end

  // WAIT preloads element 0 straight from the reciprocal unit
  assign sel     = (state == WAIT) ? '0 : idx + AW'(1);
  assign rr      = (state == EMIT) ? r : recip_out;
  assign prod    = 16'(mem[sel]) * 16'(rr);
  assign shifted = prod >> m;
  assign p       = (shifted > 16'(Q_SCALE - 1)) ? 8'hFF
                                                : shifted[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ACCUM: if (closing)   nstate = NORM;
      NORM:                 nstate = WAIT;
      WAIT:  if (wait_done) nstate = EMIT;
      EMIT:  if (last_out)  nstate = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_hs) mem[count[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      count     <= '0;
      idx       <= '0;
      r         <= '0;
      wcnt      <= '0;
      recip_in  <= 8'h80;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_hs) begin
            sum   <= sum + SW'(in_data);
            count <= count + CW'(1);
          end
        end
        NORM: begin
          recip_in <= norm_w[DW-1:0];
          wcnt     <= '0;
        end
        WAIT: begin
          if (wait_done) begin
            r         <= recip_out;
            out_data  <= p;
            out_valid <= 1'b1;
            out_last  <= (count == CW'(1));
            idx       <= '0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        EMIT: begin
          if (last_out) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sum       <= '0;
            count     <= '0;
          end else if (out_hs) begin
            idx      <= idx + AW'(1);
            out_data <= p;
            out_last <= (CW'(idx) + CW'(2) == count);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psmax_normalizer.sv
// Directed bench for psmax_normalizer with an ideal
// single-stage reciprocal unit model.
module tb_psmax_normalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] recip_in;
  logic [7:0] recip_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] vec_t [4];

  psmax_normalizer #(.N(4), .RECIP_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .recip_in  (recip_in),
    .recip_out (recip_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] recip_f(input logic [7:0] x);
    int q;
    if (x == 8'd0) return 8'hFF;
    q = 32768 / int'(x);
    return (q > 255) ? 8'hFF : 8'(q);
  endfunction

  always @(posedge clk) recip_out <= recip_f(recip_in);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      in_last  = use_last && (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat,
                          input logic [7:0] exp_recip);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({tag, "_lat"}, cnt, lat);
    chk({tag, "_recip"}, recip_in, exp_recip);
  endtask

  task automatic recv(input string tag, input vec_t e,
                      input int n, input bit bp);
    int k, g;
    bit stalled;
    logic [7:0] hd;
    logic hl;
    k = 0;
    g = 0;
    stalled = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (k < n && g < 100) begin
      out_ready = bp ? (g % 3 == 0) : 1'b1;
      if (out_valid) begin
        chk({tag, "_inrdy"}, in_ready, 1'b0);
        if (stalled) begin
          chk({tag, "_hold_d"}, out_data, hd);
          chk({tag, "_hold_l"}, out_last, hl);
        end
        if (out_ready) begin
          chk({tag, "_data"}, out_data, e[k]);
          chk({tag, "_last"}, out_last, k == n - 1);
          k++;
          stalled = 1'b0;
        end else begin
          hd = out_data;
          hl = out_last;
          stalled = 1'b1;
        end
      end
      tick();
      g++;
    end
    out_ready = 1'b1;
    chk({tag, "_count"}, k, n);
    chk({tag, "_idle_vld"}, out_valid, 1'b0);
    chk({tag, "_idle_rdy"}, in_ready, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_inrdy", in_ready, 1'b1);
    chk("rst_ovld", out_valid, 1'b0);
    chk("rst_odata", out_data, 8'h00);
    chk("rst_olast", out_last, 1'b0);
    chk("rst_recip", recip_in, 8'h80);
    chk("rst_busy", busy, 1'b0);

    send('{8'd10, 8'd20, 8'd30, 8'd40}, 4, 1'b1);
    chk("v1_busy", busy, 1'b1);
    wait_out("v1", 3, 8'd200);
    recv("v1", '{8'd25, 8'd50, 8'd76, 8'd101}, 4, 1'b0);

    send('{8'd64, 8'd64, 8'd64, 8'd64}, 4, 1'b0);
    chk("v2_close", in_ready, 1'b0);
    wait_out("v2", 3, 8'd128);
    recv("v2", '{8'd63, 8'd63, 8'd63, 8'd63}, 4, 1'b0);

    send('{8'd5, 8'd0, 8'd0, 8'd0}, 1, 1'b1);
    wait_out("v3", 3, 8'd160);
    recv("v3", '{8'd255, 8'd0, 8'd0, 8'd0}, 1, 1'b0);

    send('{8'd0, 8'd0, 8'd0, 8'd0}, 4, 1'b1);
    wait_out("v4", 3, 8'd128);
    recv("v4", '{8'd0, 8'd0, 8'd0, 8'd0}, 4, 1'b0);

    send('{8'd10, 8'd20, 8'd30, 8'd40}, 4, 1'b1);
    wait_out("bp", 3, 8'd200);
    recv("bp", '{8'd25, 8'd50, 8'd76, 8'd101}, 4, 1'b1);

    send('{8'd64, 8'd64, 8'd64, 8'd64}, 4, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_inrdy", in_ready, 1'b1);
    chk("mrst_ovld", out_valid, 1'b0);
    chk("mrst_recip", recip_in, 8'h80);
    chk("mrst_busy", busy, 1'b0);
    send('{8'd10, 8'd20, 8'd30, 8'd40}, 4, 1'b1);
    wait_out("post", 3, 8'd200);
    recv("post", '{8'd25, 8'd50, 8'd76, 8'd101}, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
